// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 Set-2 scan decoder:
//                decoder states, prefix byte values and the key event record.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } decoder_state_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

    // Keyboard status/response bytes that never describe a key press
    function automatic logic is_status_byte(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_status_byte = 1'b1;
            default:                                  is_status_byte = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ============================================================================
//  Module      : ps2_event_fifo
//  Description : Show-ahead synchronous FIFO of key events with occupancy
//                count and sticky overflow flag. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  key_event_t       i_data,
    input  logic             i_pop,
    output key_event_t       o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    key_event_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push  = i_push && (!w_full || w_pop);

    // Pointer, count and overflow bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            if (i_push && !w_push) r_overflow <= 1'b1;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Head is masked while empty so outputs read zero after reset
    assign o_head     = w_empty ? key_event_t'('0) : r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
// ============================================================================
//  Module      : ps2_scan_decoder
//  Description : Synchronises the PS/2 receiver handshake, parses Set-2
//                prefixes (E0/F0/E1) into key events and queues them in a
//                valid/ready FIFO.
//                Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated
//                make events of the key last pressed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       scan_code,
    input  logic             scan_ready,
    output logic             read,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_prime1;
    logic       r_primed;
    logic       r_flush;
    logic       r_read;
    logic [7:0] r_byte;
    logic       r_byte_vld;

    decoder_state_t r_state;
    decoder_state_t w_state_nxt;
    logic [2:0]     r_pause_cnt;
    logic [2:0]     w_pause_cnt_nxt;
    logic           w_emit;
    key_event_t     w_ev;
    logic           w_push;
    key_event_t     w_head;

    logic w_capture;
    assign w_capture = r_sync2 && !r_prev;

    // Handshake synchroniser and byte capture. The prime flops hold off the
    // "sync2 low" flush release until the synchroniser carries real samples,
    // so a byte left pending across reset is still acknowledged and dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev     <= 1'b0;
            r_prime1   <= 1'b0;
            r_primed   <= 1'b0;
            r_flush    <= 1'b1;
            r_read     <= 1'b0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_sync1    <= scan_ready;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_prime1   <= 1'b1;
            r_primed   <= r_prime1;
            r_read     <= w_capture;
            r_byte_vld <= w_capture && !r_flush;
            if (w_capture) r_byte <= scan_code;
            if (w_capture || (r_primed && !r_sync2)) r_flush <= 1'b0;
        end
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pause_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pause_cnt <= w_pause_cnt_nxt;
        end
    end

    // Prefix parser: consumes one captured byte per cycle it is valid
    always_comb begin
        w_state_nxt     = r_state;
        w_pause_cnt_nxt = r_pause_cnt;
        w_emit          = 1'b0;
        w_ev            = '{code: r_byte, ext: 1'b0, brk: 1'b0};
        if (r_byte_vld) begin
            case (r_state)
                S_IDLE: begin
                    if (r_byte == SC_EXT) begin
                        w_state_nxt = S_EXT;
                    end else if (r_byte == SC_BRK) begin
                        w_state_nxt = S_BRK;
                    end else if (r_byte == SC_PAUSE) begin
                        w_emit          = 1'b1;
                        w_pause_cnt_nxt = PAUSE_TAIL;
                        w_state_nxt     = S_PAUSE;
                    end else if (!is_status_byte(r_byte)) begin
                        w_emit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (r_byte == SC_BRK) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (r_byte != SC_EXT) begin
                        w_emit      = 1'b1;
                        w_ev.ext    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (r_byte != SC_BRK) begin
                        w_emit      = 1'b1;
                        w_ev.brk    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (r_byte != SC_BRK && r_byte != SC_EXT) begin
                        w_emit      = 1'b1;
                        w_ev.ext    = 1'b1;
                        w_ev.brk    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_PAUSE: begin
                    // Pause tail bytes are swallowed; leave when count hits 0
                    w_pause_cnt_nxt = r_pause_cnt - 3'd1;
                    if (r_pause_cnt == 3'd1) w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_last_vld;
    logic       w_match;

    assign w_match = r_last_vld && (r_last_make == {w_ev.ext, w_ev.code});
    assign w_push  = w_emit && (w_ev.brk || !w_match);

    // Remember the last pressed key; its release re-arms the filter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_make <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_emit) begin
            if (w_ev.brk) begin
                if (w_match) r_last_vld <= 1'b0;
            end else begin
                r_last_make <= {w_ev.ext, w_ev.code};
                r_last_vld  <= 1'b1;
            end
        end
    end
`else
    assign w_push = w_emit;
`endif

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_push     (w_push),
        .i_data     (w_ev),
        .i_pop      (key_ready),
        .o_head     (w_head),
        .o_valid    (key_valid),
        .o_count    (fifo_count),
        .o_overflow (overflow)
    );

    assign read      = r_read;
    assign key_code  = w_head.code;
    assign key_ext   = w_head.ext;
    assign key_break = w_head.brk;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
// ============================================================================
//  Module      : tb_ps2_scan_decoder
//  Description : Directed self-checking bench for ps2_scan_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scan_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = '0;
    logic       scan_ready = 1'b0;
    logic       read;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .read       (read),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic hold_ready);
        @(negedge clk);
        reset      = 1'b1;
        key_ready  = 1'b0;
        scan_ready = hold_ready;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        scan_code  = b;
        scan_ready = 1'b1;
        k = 0;
        while (read !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (read !== 1'b1) begin
            n_total++;
            $display("FAIL send_timeout byte=%h read=%b required=1", b, read);
        end
        scan_ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Capture the head and pop it for one cycle
    task automatic pop_one(output logic [9:0] ev);
        ev        = {key_code, key_ext, key_break};
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        n_total++;
        if ({read, key_valid, overflow, fifo_count, key_code, key_ext, key_break} !== '0)
            $display("FAIL reset_outputs got=%h required=0",
                     {read, key_valid, overflow, fifo_count, key_code, key_ext, key_break});
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_latency;
        logic [9:0] ev;
        scan_code  = 8'h1C;
        scan_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (read !== 1'b0) $display("FAIL lat_read_early got=%b required=0", read);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (read !== 1'b1 || key_valid !== 1'b0)
            $display("FAIL lat_edge2 read=%b valid=%b required read=1 valid=0", read, key_valid);
        else n_pass++;
        scan_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (read !== 1'b0) $display("FAIL lat_read_one_cycle got=%b required=0", read);
        else n_pass++;
        n_total++;
        if (key_valid !== 1'b1 || {key_code, key_ext, key_break} !== {8'h1C, 2'b00} || fifo_count !== 4'd1)
            $display("FAIL lat_event valid=%b ev=%h cnt=%0d required valid=1 ev=070 cnt=1",
                     key_valid, {key_code, key_ext, key_break}, fifo_count);
        else n_pass++;
        repeat (4) @(negedge clk);
        pop_one(ev);
        n_total++;
        if (fifo_count !== 4'd0 || key_valid !== 1'b0)
            $display("FAIL lat_pop cnt=%0d valid=%b required 0/0", fifo_count, key_valid);
        else n_pass++;
    endtask

    task automatic test_ignored;
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'h00);
        n_total++;
        if (fifo_count !== 4'd0) $display("FAIL ignored_cnt got=%0d required=0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_ext_break;
        logic [9:0] ev;
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        n_total++;
        if (fifo_count !== 4'd1) $display("FAIL extbrk_cnt got=%0d required=1", fifo_count);
        else n_pass++;
        pop_one(ev);
        n_total++;
        if (ev !== {8'h75, 2'b11}) $display("FAIL extbrk_ev got=%h required=%h", ev, {8'h75, 2'b11});
        else n_pass++;
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hF0);
        send_byte(8'h29);
        pop_one(ev);
        n_total++;
        if (ev !== {8'h6B, 2'b10}) $display("FAIL ext_make got=%h required=%h", ev, {8'h6B, 2'b10});
        else n_pass++;
        pop_one(ev);
        n_total++;
        if (ev !== {8'h29, 2'b01}) $display("FAIL plain_break got=%h required=%h", ev, {8'h29, 2'b01});
        else n_pass++;
    endtask

    task automatic test_pause;
        logic [9:0] ev;
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        foreach (seq[i]) send_byte(seq[i]);
        n_total++;
        if (fifo_count !== 4'd1) $display("FAIL pause_cnt got=%0d required=1", fifo_count);
        else n_pass++;
        send_byte(8'h1C);
        pop_one(ev);
        n_total++;
        if (ev !== {8'hE1, 2'b00}) $display("FAIL pause_ev got=%h required=%h", ev, {8'hE1, 2'b00});
        else n_pass++;
        pop_one(ev);
        n_total++;
        if (ev !== {8'h1C, 2'b00}) $display("FAIL pause_after got=%h required=%h", ev, {8'h1C, 2'b00});
        else n_pass++;
    endtask

    task automatic test_overflow;
        logic [9:0] ev;
        logic [7:0] exp_code;
        int k;
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
        n_total++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1)
            $display("FAIL ovf_full cnt=%0d ovf=%b required cnt=8 ovf=1", fifo_count, overflow);
        else n_pass++;
        // 10th byte: pop in the same cycle the push lands
        @(negedge clk);
        scan_code  = 8'h20;
        scan_ready = 1'b1;
        k = 0;
        while (read !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_total++;
        if (read !== 1'b1) $display("FAIL ovf_read_timeout read=%b required=1", read);
        else n_pass++;
        key_ready  = 1'b1;
        scan_ready = 1'b0;
        @(negedge clk);
        key_ready = 1'b0;
        n_total++;
        if (fifo_count !== 4'd8) $display("FAIL ovf_pushpop_cnt got=%0d required=8", fifo_count);
        else n_pass++;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp_code = (i == 7) ? 8'h20 : 8'h16 + 8'(i);
            pop_one(ev);
            n_total++;
            if (ev !== {exp_code, 2'b00})
                $display("FAIL ovf_drain[%0d] got=%h required=%h", i, ev, {exp_code, 2'b00});
            else n_pass++;
        end
        n_total++;
        if (fifo_count !== 4'd0 || overflow !== 1'b1)
            $display("FAIL ovf_empty cnt=%0d ovf=%b required cnt=0 ovf=1", fifo_count, overflow);
        else n_pass++;
    endtask

    task automatic test_reset_midseq;
        logic [9:0] ev;
        send_byte(8'h33);
        send_byte(8'hE0);
        send_byte(8'hF0);
        do_reset(1'b0);
        @(negedge clk);
        n_total++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0)
            $display("FAIL midrst_clear cnt=%0d ovf=%b required 0/0", fifo_count, overflow);
        else n_pass++;
        repeat (5) @(negedge clk);
        send_byte(8'h75);
        pop_one(ev);
        n_total++;
        if (ev !== {8'h75, 2'b00}) $display("FAIL midrst_ev got=%h required=%h", ev, {8'h75, 2'b00});
        else n_pass++;
    endtask

    task automatic test_stale_ready;
        logic [9:0] ev;
        int pulses;
        scan_code = 8'h5A;
        do_reset(1'b1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (read === 1'b1) pulses++;
        end
        scan_ready = 1'b0;
        repeat (6) @(negedge clk);
        n_total++;
        if (pulses !== 1) $display("FAIL stale_pulses got=%0d required=1", pulses);
        else n_pass++;
        n_total++;
        if (key_valid !== 1'b0) $display("FAIL stale_no_event valid=%b required=0", key_valid);
        else n_pass++;
        send_byte(8'h1C);
        pop_one(ev);
        n_total++;
        if (ev !== {8'h1C, 2'b00}) $display("FAIL stale_next got=%h required=%h", ev, {8'h1C, 2'b00});
        else n_pass++;
    endtask

    task automatic test_typematic;
        logic [9:0] ev;
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_FILTER_EN
        logic [9:0] exp_ev [3] = '{{8'h1C, 2'b00}, {8'h1C, 2'b01}, {8'h1C, 2'b00}};
        logic [3:0] exp_n = 4'd3;
`else
        logic [9:0] exp_ev [5] = '{{8'h1C, 2'b00}, {8'h1C, 2'b00}, {8'h1C, 2'b00},
                                   {8'h1C, 2'b01}, {8'h1C, 2'b00}};
        logic [3:0] exp_n = 4'd5;
`endif
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        foreach (seq[i]) send_byte(seq[i]);
        n_total++;
        if (fifo_count !== exp_n) $display("FAIL typem_cnt got=%0d required=%0d", fifo_count, exp_n);
        else n_pass++;
        foreach (exp_ev[i]) begin
            pop_one(ev);
            n_total++;
            if (ev !== exp_ev[i]) $display("FAIL typem_ev[%0d] got=%h required=%h", i, ev, exp_ev[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_ignored;
        test_ext_break;
        test_pause;
        test_overflow;
        test_reset_midseq;
        test_stale_ready;
        test_typematic;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
